lifo_stack_param: RTL and testbench
===================================

Name: lifo_stack_param

Overview:
Parametrised LIFO stack, successor to the team's fixed 8-entry 1-bit stack. Generalised in data width and depth. Adds simultaneous push+pop (replace-top), a registered pop output with valid, overflow/underflow sticky error flags, a level count, and programmable almost-full/almost-empty thresholds. Used as a scratch stack for parsers and call-return tracking in the playground datapath.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of entries (>=2, need not be a power of 2)
AF_LVL, DEPTH-2, almost_full asserted when count >= AF_LVL
AE_LVL, 2, almost_empty asserted when count <= AE_LVL
CNT_W, $clog2(DEPTH+1), derived width of count

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
push  input  1  write data_in onto the stack
pop  input  1  remove the top entry and return it on data_out
data_in  input  DATA_W  push data
clr_err  input  1  clears the overflow and underflow sticky flags
data_out  output  DATA_W  registered popped word; holds its value until the next accepted pop
data_valid  output  1  1-cycle pulse, the cycle after an accepted pop
top  output  DATA_W  combinational view of the current top entry; 0 when empty
count  output  CNT_W  number of stored entries, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LVL
almost_empty  output  1  count <= AE_LVL
overflow  output  1  sticky: a push was attempted while full without pop
underflow  output  1  sticky: a pop was attempted while empty

Behaviour:
- Reset (async assert, sync-release usage): ptr=0, count=0, data_out=0, data_valid=0, overflow=0, underflow=0. After reset, empty=1, full=0, almost_empty=1, almost_full=(AF_LVL==0). Memory contents are don't-care and need no reset.
- ptr points to the next free slot. The top entry is mem[ptr-1]. count==ptr. No wrap-around: ptr saturates in the range 0..DEPTH.
- Operations are decoded each cycle from push, pop, full and empty:
  - push only, !full: mem[ptr]<=data_in, ptr+1.
  - push only, full: ignored; overflow<=1.
  - pop only, !empty: data_out<=mem[ptr-1], data_valid<=1 next cycle, ptr-1.
  - pop only, empty: ignored; underflow<=1; data_valid stays 0; data_out holds.
  - push+pop, !empty: replace-top. data_out<=old mem[ptr-1], mem[ptr-1]<=data_in, data_valid<=1, ptr unchanged. Legal when full.
  - push+pop, empty: acts as push only; underflow<=1; data_valid stays 0.
  - neither: hold all state.
- Latency: a pushed word is visible on top the cycle after the push. Pop data appears on data_out with data_valid one cycle after pop is sampled.
- Status flags are combinational from the registered count.
- Errors: overflow and underflow are sticky until clr_err=1 is sampled. If clr_err and a new error occur in the same cycle, the new error wins and the flag stays 1.
- Async reset asserted mid-operation drops all state immediately. Any in-flight data_valid is lost.

Test Plan:
- Reset, then DATA_W=8, DEPTH=16: push 0x01..0x10 over 16 cycles -> count=16, full=1, almost_full set from count=14, top=0x10.
- From full, push 0xAA -> count stays 16, overflow=1, top=0x10. Then clr_err -> overflow=0.
- Pop 16 times -> data_out sequence 0x10..0x01, each with a 1-cycle data_valid. Ends empty=1, almost_empty set at count<=2.
- From empty, pop -> underflow=1, data_valid=0, data_out holds 0x01. Push+pop together while empty -> count=1, top=data_in, underflow remains 1.
- Push 0x11, 0x22, then push 0x33 with pop in the same cycle -> data_out=0x22 with data_valid, count=2, top=0x33. Repeat the replace-top while full -> count stays 16, no overflow.
- Assert rst_n=0 asynchronously mid-burst at count=5 -> count=0, empty=1, data_valid=0, flags clear, all without a clock edge.

Source files
------------

// File: rtl/lifo_stack_param_if.sv
// rtl/lifo_stack_param_if.sv - push/pop/status bundle for the parametrised LIFO stack
interface lifo_stack_param_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 5
);
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] data_in;
    logic              clr_err;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic [DATA_W-1:0] top;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;

    // Requester side: issues push/pop and observes data and status
    modport master (
        output push, pop, data_in, clr_err,
        input  data_out, data_valid, top, count, full, empty,
        input  almost_full, almost_empty, overflow, underflow
    );

    // Stack side
    modport slave (
        input  push, pop, data_in, clr_err,
        output data_out, data_valid, top, count, full, empty,
        output almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/lifo_stack_param.sv
// rtl/lifo_stack_param.sv - parametrised LIFO stack with replace-top, sticky errors and level flags
module lifo_stack_param #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    lifo_stack_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LVL);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LVL);

    logic [DATA_W-1:0] mem [DEPTH];

    // ptr_q is the next free slot and doubles as the entry count
    logic [CNT_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic              mem_we;
    logic [AW-1:0]     mem_idx;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     top_idx;
    logic              is_full;
    logic              is_empty;
    logic [DATA_W-1:0] top_word;
    logic              new_ovf;
    logic              new_udf;

    assign is_full  = (ptr_q == DEPTH_C);
    assign is_empty = (ptr_q == '0);
    assign wr_idx   = AW'(ptr_q);
    assign top_idx  = AW'(ptr_q - CNT_W'(1));
    assign top_word = mem[top_idx];

    // Decode the push/pop combination against the current fill level
    always_comb begin
        ptr_d      = ptr_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        mem_we     = 1'b0;
        mem_idx    = wr_idx;
        new_ovf    = 1'b0;
        new_udf    = 1'b0;
        case ({bus.push, bus.pop})
            2'b10: begin
                if (is_full) begin
                    new_ovf = 1'b1;
                end else begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + CNT_W'(1);
                end
            end
            2'b01: begin
                if (is_empty) begin
                    new_udf = 1'b1;
                end else begin
                    data_out_d = top_word;
                    valid_d    = 1'b1;
                    ptr_d      = ptr_q - CNT_W'(1);
                end
            end
            2'b11: begin
                if (is_empty) begin
                    // Nothing to pop: degrade to a plain push (DEPTH>=2, so never full here)
                    new_udf = 1'b1;
                    mem_we  = 1'b1;
                    ptr_d   = ptr_q + CNT_W'(1);
                end else begin
                    // Replace-top: return the old top and overwrite it in place
                    data_out_d = top_word;
                    valid_d    = 1'b1;
                    mem_we     = 1'b1;
                    mem_idx    = top_idx;
                end
            end
            default: ;
        endcase
        // A fresh error in the same cycle as clr_err keeps the flag set
        ovf_d = (ovf_q & ~bus.clr_err) | new_ovf;
        udf_d = (udf_q & ~bus.clr_err) | new_udf;
    end

    // Control and output registers, dropped immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    // Storage array; contents are meaningless above ptr so it carries no reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= bus.data_in;
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.data_valid   = valid_q;
    assign bus.top          = is_empty ? '0 : top_word;
    assign bus.count        = ptr_q;
    assign bus.full         = is_full;
    assign bus.empty        = is_empty;
    assign bus.almost_full  = (ptr_q >= AF_C);
    assign bus.almost_empty = (ptr_q <= AE_C);
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_lifo_stack_param.sv
// tb/tb_lifo_stack_param.sv - self-checking bench for lifo_stack_param
module tb_lifo_stack_param;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic clk;
    logic rst_n;

    lifo_stack_param_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    lifo_stack_param #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model: the stack as a queue, top at the back
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_valid;
    logic          m_ovf;
    logic          m_udf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge rst_n) begin
        q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            logic no, nu;
            no      = 1'b0;
            nu      = 1'b0;
            m_valid = 1'b0;
            if (bus.push && bus.pop) begin
                if (q.size() > 0) begin
                    m_dout        = q[q.size()-1];
                    q[q.size()-1] = bus.data_in;
                    m_valid       = 1'b1;
                end else begin
                    q.push_back(bus.data_in);
                    nu = 1'b1;
                end
            end else if (bus.push) begin
                if (q.size() == DEPTH) no = 1'b1;
                else q.push_back(bus.data_in);
            end else if (bus.pop) begin
                if (q.size() > 0) begin
                    m_dout  = q.pop_back();
                    m_valid = 1'b1;
                end else begin
                    nu = 1'b1;
                end
            end
            if (bus.clr_err) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
            m_ovf = m_ovf | no;
            m_udf = m_udf | nu;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        int n;
        n = q.size();
        chk("count",        32'(bus.count),        32'(n));
        chk("top",          32'(bus.top),          (n > 0) ? 32'(q[n-1]) : 32'h0);
        chk("full",         32'(bus.full),         32'(n == DEPTH));
        chk("empty",        32'(bus.empty),        32'(n == 0));
        chk("almost_full",  32'(bus.almost_full),  32'(n >= DEPTH - 2));
        chk("almost_empty", 32'(bus.almost_empty), 32'(n <= 2));
        chk("data_out",     32'(bus.data_out),     32'(m_dout));
        chk("data_valid",   32'(bus.data_valid),   32'(m_valid));
        chk("overflow",     32'(bus.overflow),     32'(m_ovf));
        chk("underflow",    32'(bus.underflow),    32'(m_udf));
    end

    task automatic step(input logic pu, input logic po, input logic [DW-1:0] d, input logic clr);
        bus.push    = pu;
        bus.pop     = po;
        bus.data_in = d;
        bus.clr_err = clr;
        @(posedge clk);
        #1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.clr_err = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.data_in = '0;
        bus.clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count",  32'(bus.count), 32'd0);
        chk("rst_empty",  32'(bus.empty), 32'd1);
        chk("rst_ae",     32'(bus.almost_empty), 32'd1);
        chk("rst_af",     32'(bus.almost_full), 32'd0);
        rst_n = 1'b1;

        // Fill 0x01..0x10
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 1'b0, DW'(i), 1'b0);
            if (i == 13) chk("af_at13", 32'(bus.almost_full), 32'd0);
            if (i == 14) chk("af_at14", 32'(bus.almost_full), 32'd1);
        end
        chk("fill_count", 32'(bus.count), 32'd16);
        chk("fill_full",  32'(bus.full),  32'd1);
        chk("fill_top",   32'(bus.top),   32'h10);

        // Overflow, then clear it
        step(1'b1, 1'b0, 8'hAA, 1'b0);
        chk("ovf_set",   32'(bus.overflow), 32'd1);
        chk("ovf_top",   32'(bus.top),      32'h10);
        chk("ovf_count", 32'(bus.count),    32'd16);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("ovf_clr",   32'(bus.overflow), 32'd0);

        // Drain: 0x10 down to 0x01
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            chk("pop_data",  32'(bus.data_out),   32'(DEPTH - i));
            chk("pop_valid", 32'(bus.data_valid), 32'd1);
        end
        @(posedge clk); #1;
        chk("valid_pulse", 32'(bus.data_valid), 32'd0);
        chk("drain_empty", 32'(bus.empty), 32'd1);

        // Underflow from empty, data_out holds
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("udf_set",   32'(bus.underflow),  32'd1);
        chk("udf_valid", 32'(bus.data_valid), 32'd0);
        chk("udf_hold",  32'(bus.data_out),   32'h01);

        // Push+pop while empty behaves as push
        step(1'b1, 1'b1, 8'h5A, 1'b0);
        chk("pp_empty_count", 32'(bus.count),      32'd1);
        chk("pp_empty_top",   32'(bus.top),        32'h5A);
        chk("pp_empty_udf",   32'(bus.underflow),  32'd1);
        chk("pp_empty_valid", 32'(bus.data_valid), 32'd0);

        // clr_err together with a new underflow: error wins
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        chk("clr_vs_new", 32'(bus.underflow), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("udf_clr", 32'(bus.underflow), 32'd0);

        // Replace-top
        step(1'b1, 1'b0, 8'h11, 1'b0);
        step(1'b1, 1'b0, 8'h22, 1'b0);
        step(1'b1, 1'b1, 8'h33, 1'b0);
        chk("rt_data",  32'(bus.data_out),   32'h22);
        chk("rt_valid", 32'(bus.data_valid), 32'd1);
        chk("rt_count", 32'(bus.count),      32'd2);
        chk("rt_top",   32'(bus.top),        32'h33);

        // Fill to full and replace-top there
        for (int i = 0; i < DEPTH - 2; i++) step(1'b1, 1'b0, DW'(8'h40 + i), 1'b0);
        step(1'b1, 1'b1, 8'h77, 1'b0);
        chk("rtf_data",  32'(bus.data_out), 32'h4D);
        chk("rtf_count", 32'(bus.count),    32'd16);
        chk("rtf_top",   32'(bus.top),      32'h77);
        chk("rtf_ovf",   32'(bus.overflow), 32'd0);

        // Set overflow, drain to 5 and reset asynchronously with data_valid high
        step(1'b1, 1'b0, 8'h99, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("pre_rst_count", 32'(bus.count),      32'd5);
        chk("pre_rst_valid", 32'(bus.data_valid), 32'd1);
        chk("pre_rst_ovf",   32'(bus.overflow),   32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(bus.count),      32'd0);
        chk("arst_empty", 32'(bus.empty),      32'd1);
        chk("arst_valid", 32'(bus.data_valid), 32'd0);
        chk("arst_ovf",   32'(bus.overflow),   32'd0);
        chk("arst_dout",  32'(bus.data_out),   32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'hC3, 1'b0);
        chk("post_rst_top", 32'(bus.top), 32'hC3);
        @(negedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
